// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared types, timing constants and helpers for the WS2812
// transmitter/receiver pair.
package ws2812_pkg;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } rx_state_t;

    localparam int PIXEL_W = 24;

    // Nominal transmitter timing in clk cycles
    localparam int T0H       = 9;
    localparam int T0L       = 22;
    localparam int T1H       = 19;
    localparam int T1L       = 16;
    localparam int RESET_NUM = 100;

    // Receiver defaults
    localparam int DEF_BIT_THRESH   = 14;
    localparam int DEF_RESET_CYCLES = 80;
    localparam int DEF_MAX_HIGH     = 40;

    // 8-bit increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ws2812_rx_sync.sv
// ws2812_rx_sync: 2-FF synchronizer for the asynchronous WS2812 line followed
// by a registered edge detector. level is the synced input delayed one more
// cycle so that it lines up with the rise/fall pulses.
module ws2812_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic synced;

    // Two-flop synchronizer bringing din into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            synced <= 1'b0;
        end else begin
            meta   <= din;
            synced <= meta;
        end
    end

    // Registered edge detect; level keeps the previous synced sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            level <= synced;
            rise  <= synced & ~level;
            fall  <= ~synced & level;
        end
    end

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 NRZ stream decoder. Measures high-pulse widths, assembles
// 24-bit LSB-first pixels, strobes pixel/latch/error events.
// Optional build macro WS2812_RX_FWD_EN: forwards the stream on dout with the
// first pixel of each frame consumed, like a real chained LED.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int BIT_THRESH   = DEF_BIT_THRESH,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int MAX_HIGH     = DEF_MAX_HIGH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic [PIXEL_W-1:0]   pixel_data,
    output logic                 pixel_valid,
    output logic [7:0]           pixel_index,
    output logic                 frame_end,
    output logic                 err,
    output logic                 dout
);

    localparam logic [7:0] THRESH  = 8'(BIT_THRESH);
    localparam logic [7:0] LATCH_N = 8'(RESET_CYCLES);
    localparam logic [7:0] HIGH_N  = 8'(MAX_HIGH);

    rx_state_t          state;
    rx_state_t          next_state;
    logic [7:0]         hcnt;
    logic [7:0]         lcnt;
    logic [4:0]         bitcnt;
    logic [PIXEL_W-1:0] shreg;
    logic [PIXEL_W-1:0] word;
    logic               level;
    logic               rise;
    logic               fall;
    logic               enter_high;
    logic               bit_done;
    logic               hi_err;
    logic               latch;
    logic               bit_val;
    logic               last_bit;

    ws2812_rx_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // Decoded bit, the word it completes, and whether this is bit 24
    assign bit_val  = (hcnt >= THRESH);
    assign word     = {bit_val, shreg[PIXEL_W-1:1]};
    assign last_bit = (bitcnt == 5'd23);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SYNC;
        else     state <= next_state;
    end

    // Next-state logic and per-cycle event decode; a rising edge in LOW wins
    // over the latch timeout, and a falling edge in HIGH wins over the error
    always_comb begin
        next_state = state;
        enter_high = 1'b0;
        bit_done   = 1'b0;
        hi_err     = 1'b0;
        latch      = 1'b0;
        case (state)
            SYNC: begin
                if (lcnt >= LATCH_N) next_state = IDLE;
            end
            IDLE: begin
                if (rise) begin
                    enter_high = 1'b1;
                    next_state = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    bit_done   = 1'b1;
                    next_state = LOW;
                end else if (hcnt >= HIGH_N) begin
                    hi_err     = 1'b1;
                    next_state = SYNC;
                end
            end
            LOW: begin
                if (rise) begin
                    enter_high = 1'b1;
                    next_state = HIGH;
                end else if (lcnt >= LATCH_N) begin
                    latch      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = SYNC;
        endcase
    end

    // High/low time counters; the entering cycle already counts as 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= 8'd0;
            lcnt <= 8'd0;
        end else begin
            if (enter_high)         hcnt <= 8'd1;
            else if (state == HIGH) hcnt <= sat_inc8(hcnt);
            else                    hcnt <= 8'd0;

            case (state)
                SYNC:    lcnt <= (level || next_state == IDLE) ? 8'd0 : sat_inc8(lcnt);
                HIGH:    lcnt <= bit_done ? 8'd1 : 8'd0;
                LOW:     lcnt <= (next_state == LOW) ? sat_inc8(lcnt) : 8'd0;
                default: lcnt <= 8'd0;
            endcase
        end
    end

    // Bit assembly and pixel hand-off; errors and latches drop partial pixels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg       <= '0;
            bitcnt      <= 5'd0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            if (bit_done) begin
                if (last_bit) begin
                    pixel_data  <= word;
                    pixel_valid <= 1'b1;
                    shreg       <= '0;
                    bitcnt      <= 5'd0;
                end else begin
                    shreg  <= word;
                    bitcnt <= bitcnt + 5'd1;
                end
            end else if (hi_err || latch) begin
                shreg  <= '0;
                bitcnt <= 5'd0;
            end
        end
    end

    // Frame/error strobes and in-frame pixel index (advances after each strobe)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_end   <= 1'b0;
            err         <= 1'b0;
            pixel_index <= 8'd0;
        end else begin
            frame_end <= latch;
            err       <= hi_err | (latch && bitcnt != 5'd0);
            if (hi_err || latch)  pixel_index <= 8'd0;
            else if (pixel_valid) pixel_index <= pixel_index + 8'd1;
        end
    end

`ifdef WS2812_RX_FWD_EN
    logic fwd_en;

    // Forwarding opens once the first pixel of a frame is consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      fwd_en <= 1'b0;
        else if (hi_err || latch)     fwd_en <= 1'b0;
        else if (bit_done && last_bit) fwd_en <= 1'b1;
    end

    assign dout = level & fwd_en;
`else
    assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: randomized self-checking bench for ws2812_rx. Pixels are
// generated as words, serialized with chosen pulse widths, and the expected
// pixel/index/latch/error events are derived from the protocol rules.
module tb_ws2812_rx;
    import ws2812_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [7:0]  pixel_index;
    logic        frame_end;
    logic        err;
    logic        dout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [23:0] pix_q[$];
    logic [7:0]  idx_q[$];
    logic [23:0] exp_data_q[$];
    int          exp_idx_q[$];
    int          frame_pos = 0;
    int          fe_cnt = 0;
    int          err_cnt = 0;
    int          both_cnt = 0;
    int          last_err_cyc = 0;

    logic        din_hist[0:65535];
    logic        tag_hist[0:65535];
    logic        cur_tag = 1'b0;
    logic        fwd_watch = 1'b0;
    logic        fwd_exp;
    int          fwd_bad = 0;
    int          fwd_ones = 0;

    ws2812_rx dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_index (pixel_index),
        .frame_end   (frame_end),
        .err         (err),
        .dout        (dout)
    );

    always #5 clk = ~clk;

    // Cycle count and input history, sampled at the active edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < 65536) begin
            din_hist[cyc] = din;
            tag_hist[cyc] = cur_tag;
        end
    end

    // Event monitor, sampled mid-cycle; forwarded output should equal the
    // line as it was three cycles earlier once pixel 1 of the frame starts
    always @(negedge clk) begin
        if (!rst) begin
            if (pixel_valid) begin
                pix_q.push_back(pixel_data);
                idx_q.push_back(pixel_index);
            end
            if (frame_end) fe_cnt++;
            if (err) begin
                err_cnt++;
                last_err_cyc = cyc;
            end
            if (err && frame_end) both_cnt++;
            if (fwd_watch && cyc >= 3 && cyc < 65536) begin
                fwd_exp = tag_hist[cyc-2] ? din_hist[cyc-2] : 1'b0;
                if (fwd_exp) fwd_ones++;
                if (dout !== fwd_exp) fwd_bad++;
            end
        end
    end

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din = v;
        end
    endtask

    // mode 0: nominal timing, 1: random widths on the correct side of the
    // threshold, 2: boundary widths 13 (zero) / 14 (one)
    task automatic send_bits(input logic [23:0] w, input int nbits, input int mode);
        int h;
        int l;
        for (int b = 0; b < nbits; b++) begin
            case (mode)
                0: begin
                    h = w[b] ? T1H : T0H;
                    l = w[b] ? T1L : T0L;
                end
                1: begin
                    h = w[b] ? int'($urandom_range(32, 14)) : int'($urandom_range(13, 4));
                    l = int'($urandom_range(40, 8));
                end
                default: begin
                    h = w[b] ? 14 : 13;
                    l = 20;
                end
            endcase
            drive(1'b1, h);
            drive(1'b0, l);
        end
    endtask

    task automatic frame_pixel(input logic [23:0] w, input int mode);
        exp_data_q.push_back(w);
        exp_idx_q.push_back(frame_pos);
        frame_pos++;
        send_bits(w, 24, mode);
    endtask

    task automatic send_latch();
        drive(1'b0, RESET_NUM);
        frame_pos = 0;
    endtask

    task automatic clear_obs();
        pix_q.delete();
        idx_q.delete();
        exp_data_q.delete();
        exp_idx_q.delete();
        fe_cnt   = 0;
        err_cnt  = 0;
        both_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({pixel_data, pixel_valid, pixel_index, frame_end, err, dout} !== 36'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%h want=0",
                     {pixel_data, pixel_valid, pixel_index, frame_end, err, dout});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_pixel();
        clear_obs();
        drive(1'b0, RESET_NUM);
        frame_pixel(24'hA5C3F0, 0);
        send_latch();
        total++;
        if (pix_q.size() !== 1) begin
            bad++; $display("[TB] FAIL single_count got=%0d want=1", pix_q.size());
        end
        for (int i = 0; i < pix_q.size() && i < 1; i++) begin
            total++;
            if (pix_q[i] !== 24'hA5C3F0) begin
                bad++; $display("[TB] FAIL single_data got=%h want=a5c3f0", pix_q[i]);
            end
            total++;
            if (idx_q[i] !== 8'd0) begin
                bad++; $display("[TB] FAIL single_index got=%0d want=0", idx_q[i]);
            end
        end
        total++;
        if (fe_cnt !== 1 || err_cnt !== 0) begin
            bad++; $display("[TB] FAIL single_events got fe=%0d err=%0d want fe=1 err=0", fe_cnt, err_cnt);
        end
    endtask

    task automatic test_multi_pixel();
        clear_obs();
        frame_pixel(24'h000001, 0);
        frame_pixel(24'h800000, 0);
        frame_pixel(24'hFFFFFF, 0);
        send_latch();
        frame_pixel(24'($urandom), 1);
        send_latch();
        total++;
        if (pix_q.size() !== exp_data_q.size()) begin
            bad++; $display("[TB] FAIL multi_count got=%0d want=%0d", pix_q.size(), exp_data_q.size());
        end
        for (int i = 0; i < pix_q.size() && i < exp_data_q.size(); i++) begin
            total++;
            if (pix_q[i] !== exp_data_q[i]) begin
                bad++; $display("[TB] FAIL multi_data[%0d] got=%h want=%h", i, pix_q[i], exp_data_q[i]);
            end
            total++;
            if (idx_q[i] !== 8'(exp_idx_q[i])) begin
                bad++; $display("[TB] FAIL multi_index[%0d] got=%0d want=%0d", i, idx_q[i], exp_idx_q[i]);
            end
        end
        total++;
        if (fe_cnt !== 2 || err_cnt !== 0) begin
            bad++; $display("[TB] FAIL multi_events got fe=%0d err=%0d want fe=2 err=0", fe_cnt, err_cnt);
        end
    endtask

    task automatic test_boundary();
        clear_obs();
        frame_pixel(24'($urandom), 2);
        frame_pixel(24'hAAAAAA, 2);
        send_latch();
        total++;
        if (pix_q.size() !== exp_data_q.size()) begin
            bad++; $display("[TB] FAIL boundary_count got=%0d want=%0d", pix_q.size(), exp_data_q.size());
        end
        for (int i = 0; i < pix_q.size() && i < exp_data_q.size(); i++) begin
            total++;
            if (pix_q[i] !== exp_data_q[i]) begin
                bad++; $display("[TB] FAIL boundary_data[%0d] got=%h want=%h", i, pix_q[i], exp_data_q[i]);
            end
        end
    endtask

    task automatic test_random_frames();
        int npix;
        clear_obs();
        for (int f = 0; f < 4; f++) begin
            npix = int'($urandom_range(3, 1));
            for (int p = 0; p < npix; p++) frame_pixel(24'($urandom), 1);
            send_latch();
        end
        total++;
        if (pix_q.size() !== exp_data_q.size()) begin
            bad++; $display("[TB] FAIL random_count got=%0d want=%0d", pix_q.size(), exp_data_q.size());
        end
        for (int i = 0; i < pix_q.size() && i < exp_data_q.size(); i++) begin
            total++;
            if (pix_q[i] !== exp_data_q[i] || idx_q[i] !== 8'(exp_idx_q[i])) begin
                bad++;
                $display("[TB] FAIL random_pixel[%0d] got=%h/%0d want=%h/%0d",
                         i, pix_q[i], idx_q[i], exp_data_q[i], exp_idx_q[i]);
            end
        end
        total++;
        if (fe_cnt !== 4 || err_cnt !== 0) begin
            bad++; $display("[TB] FAIL random_events got fe=%0d err=%0d want fe=4 err=0", fe_cnt, err_cnt);
        end
    endtask

    task automatic test_truncated();
        clear_obs();
        send_bits(24'($urandom), 10, 0);
        send_latch();
        total++;
        if (fe_cnt !== 1 || err_cnt !== 1 || both_cnt !== 1 || pix_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL trunc_events got fe=%0d err=%0d both=%0d pix=%0d want 1/1/1/0",
                     fe_cnt, err_cnt, both_cnt, pix_q.size());
        end
        clear_obs();
        frame_pixel(24'($urandom), 0);
        send_latch();
        total++;
        if (pix_q.size() !== 1 || err_cnt !== 0) begin
            bad++; $display("[TB] FAIL trunc_recover_count got pix=%0d err=%0d want 1/0", pix_q.size(), err_cnt);
        end else if (pix_q[0] !== exp_data_q[0] || idx_q[0] !== 8'd0) begin
            bad++; $display("[TB] FAIL trunc_recover_data got=%h/%0d want=%h/0", pix_q[0], idx_q[0], exp_data_q[0]);
        end
    endtask

    task automatic test_long_high();
        int start;
        clear_obs();
        @(negedge clk);
        din   = 1'b1;
        start = cyc;
        drive(1'b1, 49);
        drive(1'b0, 20);
        send_bits(24'($urandom), 24, 0);
        drive(1'b0, RESET_NUM);
        // 3-cycle input latency, hcnt=1 on the 4th edge, 40 on the 43rd,
        // error registered on the 44th
        total++;
        if (err_cnt !== 1 || last_err_cyc !== start + 44) begin
            bad++;
            $display("[TB] FAIL long_high_err got cnt=%0d at=%0d want cnt=1 at=%0d",
                     err_cnt, last_err_cyc - start, 44);
        end
        total++;
        if (pix_q.size() !== 0 || fe_cnt !== 0) begin
            bad++; $display("[TB] FAIL long_high_quiet got pix=%0d fe=%0d want 0/0", pix_q.size(), fe_cnt);
        end
        clear_obs();
        frame_pixel(24'($urandom), 1);
        send_latch();
        total++;
        if (pix_q.size() !== 1 || fe_cnt !== 1) begin
            bad++; $display("[TB] FAIL long_high_recover got pix=%0d fe=%0d want 1/1", pix_q.size(), fe_cnt);
        end else if (pix_q[0] !== exp_data_q[0] || idx_q[0] !== 8'd0) begin
            bad++; $display("[TB] FAIL long_high_data got=%h/%0d want=%h/0", pix_q[0], idx_q[0], exp_data_q[0]);
        end
    endtask

    task automatic test_reset_mid_pixel();
        logic [23:0] w0;
        clear_obs();
        w0 = 24'($urandom) | 24'h000100;
        frame_pixel(w0, 0);
        send_bits(24'($urandom), 5, 0);
        drive(1'b1, 8);
        total++;
        if (pixel_data !== w0 || pixel_index !== 8'd1) begin
            bad++; $display("[TB] FAIL pre_reset_state got=%h/%0d want=%h/1", pixel_data, pixel_index, w0);
        end
`ifdef WS2812_RX_FWD_EN
        total++;
        if (dout !== 1'b1) begin
            bad++; $display("[TB] FAIL pre_reset_dout got=%b want=1", dout);
        end
`endif
        #2 rst = 1'b1;
        #1;
        total++;
        if ({pixel_data, pixel_valid, pixel_index, frame_end, err, dout} !== 36'd0) begin
            bad++;
            $display("[TB] FAIL mid_reset_outputs got=%h want=0",
                     {pixel_data, pixel_valid, pixel_index, frame_end, err, dout});
        end
        @(negedge clk);
        din = 1'b0;
        rst = 1'b0;
        clear_obs();
        frame_pos = 0;
        drive(1'b0, RESET_NUM);
        frame_pixel(24'($urandom), 0);
        send_latch();
        total++;
        if (pix_q.size() !== 1 || fe_cnt !== 1) begin
            bad++; $display("[TB] FAIL post_reset_count got pix=%0d fe=%0d want 1/1", pix_q.size(), fe_cnt);
        end else if (pix_q[0] !== exp_data_q[0] || idx_q[0] !== 8'd0) begin
            bad++; $display("[TB] FAIL post_reset_data got=%h/%0d want=%h/0", pix_q[0], idx_q[0], exp_data_q[0]);
        end
    endtask

`ifdef WS2812_RX_FWD_EN
    task automatic test_forward();
        clear_obs();
        fwd_bad   = 0;
        fwd_ones  = 0;
        cur_tag   = 1'b0;
        fwd_watch = 1'b1;
        frame_pixel(24'($urandom), 1);
        cur_tag = 1'b1;
        frame_pixel(24'($urandom) | 24'h000001, 1);
        send_latch();
        fwd_watch = 1'b0;
        cur_tag   = 1'b0;
        total++;
        if (fwd_bad !== 0 || fwd_ones === 0) begin
            bad++; $display("[TB] FAIL forward_dout got bad_cycles=%0d high_cycles=%0d want 0/>0", fwd_bad, fwd_ones);
        end
        total++;
        if (pix_q.size() !== 2 || fe_cnt !== 1) begin
            bad++; $display("[TB] FAIL forward_pixels got pix=%0d fe=%0d want 2/1", pix_q.size(), fe_cnt);
        end
    endtask
`endif

    initial begin
        $display("[TB] ws2812_rx bench start");
        test_reset();
        test_single_pixel();
        test_multi_pixel();
        test_boundary();
        test_random_frames();
        test_truncated();
        test_long_high();
`ifdef WS2812_RX_FWD_EN
        test_forward();
`endif
        test_reset_mid_pixel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
